// File: rtl/flow_pifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pifo_headers
//   Shared constants and types for the flow-level PIFO controller.
//   FlowId / Priority describe the default configuration; FlowCtrlState is the
//   controller FSM encoding.
// -----------------------------------------------------------------------------
package pifo_headers;

   localparam int NUM_FLOWS        = 8;
   localparam int FIFO_DEPTH       = 16;
   localparam int PRIO_WIDTH       = 16;
   localparam int FIFO_COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);
   localparam int FLOW_ID_WIDTH    = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;

   typedef logic [FLOW_ID_WIDTH-1:0] FlowId;
   typedef logic [PRIO_WIDTH-1:0]    Priority;

   typedef enum logic {
      IDLE     = 1'b0,
      REINSERT = 1'b1
   } FlowCtrlState;

endpackage

// File: rtl/flow_pifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// flow_pifo_ctrl_if
//   Bundles every non-clock/reset signal of flow_pifo_ctrl.
//   master : the controller (drives the o__* signals)
//   slave  : the surrounding ingress/egress logic, flow FIFOs and pifo_set
//   Groups: enqueue request/ready, dequeue request/valid/flow id,
//           per-flow FIFO strobes + head priorities, pifo_set push/pop, empty.
// -----------------------------------------------------------------------------
interface flow_pifo_ctrl_if #(
   parameter int NUM_FLOWS  = 8,
   parameter int PRIO_WIDTH = 16
);
   localparam int ID_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;

   logic                                 i__enqueue;
   logic [ID_W-1:0]                      i__enqueue_flow_id;
   logic [PRIO_WIDTH-1:0]                i__enqueue_priority;
   logic                                 o__enqueue_ready;
   logic                                 i__dequeue;
   logic                                 o__dequeue_valid;
   logic [ID_W-1:0]                      o__dequeue_flow_id;
   logic [NUM_FLOWS-1:0]                 o__fifo_enqueue;
   logic [NUM_FLOWS-1:0]                 o__fifo_dequeue;
   logic [NUM_FLOWS-1:0][PRIO_WIDTH-1:0] i__fifo_head_priority;
   logic                                 o__pifo_push_valid;
   logic [ID_W-1:0]                      o__pifo_push_flow_id;
   logic [PRIO_WIDTH-1:0]                o__pifo_push_priority;
   logic                                 i__pifo_push_ready;
   logic                                 i__pifo_pop_valid;
   logic [ID_W-1:0]                      i__pifo_pop_flow_id;
   logic                                 o__pifo_pop;
   logic                                 o__empty;

   modport master (
      input  i__enqueue, i__enqueue_flow_id, i__enqueue_priority, i__dequeue,
             i__fifo_head_priority, i__pifo_push_ready, i__pifo_pop_valid,
             i__pifo_pop_flow_id,
      output o__enqueue_ready, o__dequeue_valid, o__dequeue_flow_id,
             o__fifo_enqueue, o__fifo_dequeue, o__pifo_push_valid,
             o__pifo_push_flow_id, o__pifo_push_priority, o__pifo_pop, o__empty
   );

   modport slave (
      output i__enqueue, i__enqueue_flow_id, i__enqueue_priority, i__dequeue,
             i__fifo_head_priority, i__pifo_push_ready, i__pifo_pop_valid,
             i__pifo_pop_flow_id,
      input  o__enqueue_ready, o__dequeue_valid, o__dequeue_flow_id,
             o__fifo_enqueue, o__fifo_dequeue, o__pifo_push_valid,
             o__pifo_push_flow_id, o__pifo_push_priority, o__pifo_pop, o__empty
   );

endinterface

// File: rtl/flow_pifo_ctrl_count_table.sv
// -----------------------------------------------------------------------------
// flow_count_table
//   Per-flow packet counters and PIFO-membership bits.
//   clk, reset        : clock, synchronous active-high reset
//   inc_en/inc_idx    : +1 on one flow (enqueue accepted)
//   dec_en/dec_idx    : -1 on one flow (dequeue accepted); may hit the same
//                       flow as inc in one cycle, leaving the count unchanged
//   set_pifo_en/idx   : mark a flow as present in pifo_set
//   clr_pifo_en/idx   : mark a flow as absent from pifo_set
//   count, in_pifo    : registered state per flow
//   all_zero          : every counter is zero
// -----------------------------------------------------------------------------
module flow_count_table #(
   parameter int NUM_FLOWS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1),
   parameter int ID_W       = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            inc_en,
   input  logic [ID_W-1:0]                 inc_idx,
   input  logic                            dec_en,
   input  logic [ID_W-1:0]                 dec_idx,
   input  logic                            set_pifo_en,
   input  logic [ID_W-1:0]                 set_pifo_idx,
   input  logic                            clr_pifo_en,
   input  logic [ID_W-1:0]                 clr_pifo_idx,
   output logic [NUM_FLOWS-1:0][CNT_W-1:0] count,
   output logic [NUM_FLOWS-1:0]            in_pifo,
   output logic                            all_zero
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FLOWS; gi++) begin : g_flow
         logic [CNT_W-1:0] count_reg;
         logic             in_pifo_reg;
         logic             inc_hit;
         logic             dec_hit;
         logic             set_hit;
         logic             clr_hit;

         assign inc_hit = inc_en      && (inc_idx      == ID_W'(gi));
         assign dec_hit = dec_en      && (dec_idx      == ID_W'(gi));
         assign set_hit = set_pifo_en && (set_pifo_idx == ID_W'(gi));
         assign clr_hit = clr_pifo_en && (clr_pifo_idx == ID_W'(gi));

         always_ff @(posedge clk) begin
            if (reset) begin
               count_reg   <= '0;
               in_pifo_reg <= 1'b0;
            end else begin
               // inc and dec together cancel out
               if (inc_hit && !dec_hit) begin
                  count_reg <= count_reg + CNT_W'(1);
               end else if (dec_hit && !inc_hit) begin
                  count_reg <= count_reg - CNT_W'(1);
               end
               if (set_hit) begin
                  in_pifo_reg <= 1'b1;
               end else if (clr_hit) begin
                  in_pifo_reg <= 1'b0;
               end
            end
         end

         assign count[gi]   = count_reg;
         assign in_pifo[gi] = in_pifo_reg;
      end
   endgenerate

   assign all_zero = ~|count;

endmodule

// File: rtl/flow_pifo_ctrl.sv
// -----------------------------------------------------------------------------
// flow_pifo_ctrl
//   Sequencing controller for the flow-level PIFO. A flow is held in pifo_set
//   exactly while its FIFO is non-empty, ranked by its head-packet priority.
//   A pop of a flow that still has packets is followed by a one-cycle
//   REINSERT state that pushes the flow back with its new head priority.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : enqueue/dequeue handshakes, flow FIFO strobes and head
//           priorities, pifo_set push/pop, empty flag (see flow_pifo_ctrl_if)
// -----------------------------------------------------------------------------
module flow_pifo_ctrl
   import pifo_headers::*;
#(
   parameter int NUM_FLOWS  = pifo_headers::NUM_FLOWS,
   parameter int FIFO_DEPTH = pifo_headers::FIFO_DEPTH,
   parameter int PRIO_WIDTH = pifo_headers::PRIO_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   flow_pifo_ctrl_if.master bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ID_W  = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;

   FlowCtrlState state_reg, state_next;
   logic [ID_W-1:0] reinsert_fid_reg, reinsert_fid_next;

   logic [NUM_FLOWS-1:0][CNT_W-1:0] count;
   logic [NUM_FLOWS-1:0]            in_pifo;
   logic                            all_zero;

   logic [ID_W-1:0] enq_fid;
   logic [ID_W-1:0] pop_fid;
   logic            enq_ready;
   logic            enq_accept;
   logic            new_push;
   logic            deq_valid;
   logic            deq_accept;
   logic            reinsert_needed;

   assign enq_fid = bus.i__enqueue_flow_id;
   assign pop_fid = bus.i__pifo_pop_flow_id;

   assign enq_ready  = (state_reg == IDLE)
                    && (count[enq_fid] < CNT_W'(FIFO_DEPTH))
                    && (in_pifo[enq_fid] || bus.i__pifo_push_ready);
   assign enq_accept = bus.i__enqueue && enq_ready;
   assign new_push   = enq_accept && !in_pifo[enq_fid];

   assign deq_valid  = (state_reg == IDLE) && bus.i__pifo_pop_valid;
   assign deq_accept = bus.i__dequeue && deq_valid;

   // Packets left in the popped flow after this cycle: count-1 plus a
   // same-cycle enqueue to it. A popped flow always holds at least one
   // packet, so "remaining > 0" reduces to the form below.
   assign reinsert_needed = deq_accept
                         && ((count[pop_fid] > CNT_W'(1))
                             || (enq_accept && (enq_fid == pop_fid)));

   flow_count_table #(
      .NUM_FLOWS (NUM_FLOWS),
      .FIFO_DEPTH(FIFO_DEPTH),
      .CNT_W     (CNT_W),
      .ID_W      (ID_W)
   ) u_count_table (
      .clk         (clk),
      .reset       (reset),
      .inc_en      (enq_accept),
      .inc_idx     (enq_fid),
      .dec_en      (deq_accept),
      .dec_idx     (pop_fid),
      .set_pifo_en (new_push),
      .set_pifo_idx(enq_fid),
      // a committed reinsert keeps the flow counted as present in pifo_set
      .clr_pifo_en (deq_accept && !reinsert_needed),
      .clr_pifo_idx(pop_fid),
      .count       (count),
      .in_pifo     (in_pifo),
      .all_zero    (all_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= IDLE;
         reinsert_fid_reg <= '0;
      end else begin
         state_reg        <= state_next;
         reinsert_fid_reg <= reinsert_fid_next;
      end
   end

   always_comb begin
      state_next                = state_reg;
      reinsert_fid_next         = reinsert_fid_reg;
      bus.o__pifo_push_valid    = 1'b0;
      bus.o__pifo_push_flow_id  = enq_fid;
      bus.o__pifo_push_priority = bus.i__enqueue_priority;

      case (state_reg)
         IDLE: begin
            bus.o__pifo_push_valid = new_push;
            if (reinsert_needed) begin
               state_next        = REINSERT;
               reinsert_fid_next = pop_fid;
            end
         end
         REINSERT: begin
            // head priority register already reflects the post-pop head
            bus.o__pifo_push_valid    = 1'b1;
            bus.o__pifo_push_flow_id  = reinsert_fid_reg;
            bus.o__pifo_push_priority = bus.i__fifo_head_priority[reinsert_fid_reg];
            if (bus.i__pifo_push_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.o__enqueue_ready   = enq_ready;
   assign bus.o__dequeue_valid   = deq_valid;
   assign bus.o__dequeue_flow_id = pop_fid;
   assign bus.o__pifo_pop        = deq_accept;
   assign bus.o__fifo_enqueue    = enq_accept ? (NUM_FLOWS'(1) << enq_fid) : '0;
   assign bus.o__fifo_dequeue    = deq_accept ? (NUM_FLOWS'(1) << pop_fid) : '0;
   assign bus.o__empty           = all_zero;

endmodule
